// File: rtl/sensemi_regs_pkg.sv
// sensemi_regs_pkg
// Shared definitions for the sensemi register bank: word offsets of every
// mapped register, CTRL bit positions and the CTRL readback layout.
// No ports (package).

package sensemi_regs_pkg;

    // Word offsets (byte address >> 2)
    localparam int unsigned REG_ID_OFS         = 0;
    localparam int unsigned REG_VERSION_OFS    = 1;
    localparam int unsigned REG_SCRATCH_OFS    = 2;
    localparam int unsigned REG_CTRL_OFS       = 3;
    localparam int unsigned REG_STATUS_OFS     = 4;
    localparam int unsigned REG_IRQ_STATUS_OFS = 5;
    localparam int unsigned REG_IRQ_MASK_OFS   = 6;
    localparam int unsigned REG_EVENT_CNT_OFS  = 7;

    // CTRL bit positions
    localparam int unsigned CTRL_ENABLE_BIT   = 0;
    localparam int unsigned CTRL_SOFT_RST_BIT = 1;
    localparam int unsigned CTRL_CNT_CLR_BIT  = 2;
    localparam int unsigned CTRL_MODE_LSB     = 4;
    localparam int unsigned CTRL_MODE_W       = 4;

    // CTRL as seen on the bus; pulse bits and reserved bits always read 0
    typedef struct packed {
        logic [23:0] rsvd_hi;
        logic [3:0]  mode;
        logic        rsvd3;
        logic        cnt_clr;
        logic        soft_rst;
        logic        enable;
    } ctrl_reg_t;

endpackage

// File: rtl/sensemi_axi_regs_if.sv
// sensemi_axi_regs_if
// Simple register-access channel between the AXI-Lite front end (master) and
// the register bank (slave). Offsets are word offsets (ADDR_WIDTH-2 bits).
// Signals: wren/wr_offset/wdata (write strobe), rden/rd_offset (read strobe),
// rdata (registered read data from the slave, valid one cycle after rden).

interface sensemi_axi_regs_if #(
    parameter int unsigned ADDR_WIDTH = 13
);
    logic                  wren;
    logic [ADDR_WIDTH-3:0] wr_offset;
    logic [31:0]           wdata;
    logic                  rden;
    logic [ADDR_WIDTH-3:0] rd_offset;
    logic [31:0]           rdata;

    modport master (
        output wren, wr_offset, wdata, rden, rd_offset,
        input  rdata
    );

    modport slave (
        input  wren, wr_offset, wdata, rden, rd_offset,
        output rdata
    );
endinterface

// File: rtl/sensemi_sat_counter.sv
// sensemi_sat_counter
// Saturating up-counter with synchronous clear. Clear and increment in the
// same cycle yield 1 so the coincident event is not lost.
// Ports: clk_i, rst_ni (async active-low), inc_i, clr_i, count_o[WIDTH-1:0].

module sensemi_sat_counter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = inc_i ? WIDTH'(1) : '0;
        end else if (inc_i && (count_q != '1)) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/sensemi_axi_regs_bank.sv
// sensemi_axi_regs_bank
// Register bank behind sensemi_axi_regs_if: ID, VERSION, SCRATCH, CTRL,
// STATUS, sticky IRQ_STATUS (W1C), IRQ_MASK and a saturating EVENT_CNT.
// Ports:
//   s_axi_aclk, s_axi_aresetn  clock / async active-low reset
//   regs                       register-access channel (slave side)
//   ctrl_enable_o, ctrl_mode_o CTRL fields
//   soft_rst_o                 one-cycle pulse after a write of CTRL[1]=1
//   status_i                   live status, read through STATUS
//   irq_event_i                per-source event pulses into IRQ_STATUS
//   cnt_event_i                EVENT_CNT increment strobe
//   irq_o                      registered OR of IRQ_STATUS & IRQ_MASK
// Build option: SENSEMI_REGS_CNT_CLR_ON_READ_EN makes a read of EVENT_CNT
// clear it; otherwise EVENT_CNT is cleared by writing CTRL[2]=1.

module sensemi_axi_regs_bank
    import sensemi_regs_pkg::*;
#(
    parameter int unsigned AXI_ADDR_WIDTH = 13,
    parameter int unsigned AXI_DATA_WIDTH = 32,
    parameter logic [31:0] BLOCK_ID       = 32'h5345_4E53,
    parameter logic [31:0] VERSION        = 32'h0001_0000,
    parameter int unsigned NUM_IRQ        = 8,
    parameter int unsigned STATUS_W       = 16,
    parameter int unsigned CNT_W          = 32
) (
    input  logic                 s_axi_aclk,
    input  logic                 s_axi_aresetn,
    sensemi_axi_regs_if.slave    regs,
    output logic                 ctrl_enable_o,
    output logic [3:0]           ctrl_mode_o,
    output logic                 soft_rst_o,
    input  logic [STATUS_W-1:0]  status_i,
    input  logic [NUM_IRQ-1:0]   irq_event_i,
    input  logic                 cnt_event_i,
    output logic                 irq_o
);

    localparam int unsigned OFS_W = AXI_ADDR_WIDTH - 2;

    if (AXI_DATA_WIDTH != 32) begin : g_bad_data_width
        $error("sensemi_axi_regs_bank: only AXI_DATA_WIDTH=32 is supported");
    end
    if (NUM_IRQ < 1 || NUM_IRQ > 32) begin : g_bad_num_irq
        $error("sensemi_axi_regs_bank: NUM_IRQ must be 1..32");
    end
    if (STATUS_W < 1 || STATUS_W > 32) begin : g_bad_status_w
        $error("sensemi_axi_regs_bank: STATUS_W must be 1..32");
    end
    if (CNT_W < 1 || CNT_W > 32) begin : g_bad_cnt_w
        $error("sensemi_axi_regs_bank: CNT_W must be 1..32");
    end

    logic [31:0]        scratch_q;
    logic               ctrl_enable_q;
    logic [3:0]         ctrl_mode_q;
    logic               soft_rst_q;
    logic [NUM_IRQ-1:0] irq_status_q;
    logic [NUM_IRQ-1:0] irq_status_d;
    logic [NUM_IRQ-1:0] irq_mask_q;
    logic               irq_q;
    logic [31:0]        rdata_q;
    logic [31:0]        rd_word;
    logic [CNT_W-1:0]   event_cnt;
    logic               cnt_clr;
    ctrl_reg_t          ctrl_rd;

    // Write decode
    logic wr_scratch, wr_ctrl, wr_irq_status, wr_irq_mask;

    assign wr_scratch    = regs.wren && (regs.wr_offset == OFS_W'(REG_SCRATCH_OFS));
    assign wr_ctrl       = regs.wren && (regs.wr_offset == OFS_W'(REG_CTRL_OFS));
    assign wr_irq_status = regs.wren && (regs.wr_offset == OFS_W'(REG_IRQ_STATUS_OFS));
    assign wr_irq_mask   = regs.wren && (regs.wr_offset == OFS_W'(REG_IRQ_MASK_OFS));

    // Event set is OR'd in after the W1C clear so a coincident event wins
    always_comb begin
        irq_status_d = irq_status_q;
        if (wr_irq_status) begin
            irq_status_d = irq_status_d & ~regs.wdata[NUM_IRQ-1:0];
        end
        irq_status_d = irq_status_d | irq_event_i;
    end

`ifdef SENSEMI_REGS_CNT_CLR_ON_READ_EN
    assign cnt_clr = regs.rden && (regs.rd_offset == OFS_W'(REG_EVENT_CNT_OFS));
`else
    assign cnt_clr = wr_ctrl && regs.wdata[CTRL_CNT_CLR_BIT];
`endif

    sensemi_sat_counter #(
        .WIDTH (CNT_W)
    ) u_event_cnt (
        .clk_i   (s_axi_aclk),
        .rst_ni  (s_axi_aresetn),
        .inc_i   (cnt_event_i),
        .clr_i   (cnt_clr),
        .count_o (event_cnt)
    );

    // Read mux; sees pre-write state so a same-cycle write is not visible
    always_comb begin
        ctrl_rd        = '0;
        ctrl_rd.enable = ctrl_enable_q;
        ctrl_rd.mode   = ctrl_mode_q;
        rd_word        = 32'h0;
        case (regs.rd_offset)
            OFS_W'(REG_ID_OFS):         rd_word = BLOCK_ID;
            OFS_W'(REG_VERSION_OFS):    rd_word = VERSION;
            OFS_W'(REG_SCRATCH_OFS):    rd_word = scratch_q;
            OFS_W'(REG_CTRL_OFS):       rd_word = ctrl_rd;
            OFS_W'(REG_STATUS_OFS):     rd_word = 32'(status_i);
            OFS_W'(REG_IRQ_STATUS_OFS): rd_word = 32'(irq_status_q);
            OFS_W'(REG_IRQ_MASK_OFS):   rd_word = 32'(irq_mask_q);
            OFS_W'(REG_EVENT_CNT_OFS):  rd_word = 32'(event_cnt);
            default:                    rd_word = 32'h0;
        endcase
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            scratch_q     <= '0;
            ctrl_enable_q <= 1'b0;
            ctrl_mode_q   <= '0;
            soft_rst_q    <= 1'b0;
            irq_status_q  <= '0;
            irq_mask_q    <= '0;
            irq_q         <= 1'b0;
            rdata_q       <= '0;
        end else begin
            if (wr_scratch) begin
                scratch_q <= regs.wdata;
            end
            if (wr_ctrl) begin
                ctrl_enable_q <= regs.wdata[CTRL_ENABLE_BIT];
                ctrl_mode_q   <= regs.wdata[CTRL_MODE_LSB +: CTRL_MODE_W];
            end
            soft_rst_q <= wr_ctrl && regs.wdata[CTRL_SOFT_RST_BIT];
            if (wr_irq_mask) begin
                irq_mask_q <= regs.wdata[NUM_IRQ-1:0];
            end
            irq_status_q <= irq_status_d;
            irq_q        <= |(irq_status_q & irq_mask_q);
            if (regs.rden) begin
                rdata_q <= rd_word;
            end
        end
    end

    assign regs.rdata    = rdata_q;
    assign ctrl_enable_o = ctrl_enable_q;
    assign ctrl_mode_o   = ctrl_mode_q;
    assign soft_rst_o    = soft_rst_q;
    assign irq_o         = irq_q;

endmodule

// File: tb/tb_sensemi_axi_regs_bank.sv
// tb_sensemi_axi_regs_bank
// Self-checking bench: directed scenarios plus a randomized run, all checked
// against a behavioural model of the register map kept in this file.

module tb_sensemi_axi_regs_bank;

    localparam logic [31:0] EXP_ID  = 32'h5345_4E53;
    localparam logic [31:0] EXP_VER = 32'h0001_0000;

    logic        clk;
    logic        rst_n;
    logic [15:0] status;
    logic [7:0]  irq_ev;
    logic        cnt_ev;
    logic        ctrl_enable;
    logic [3:0]  ctrl_mode;
    logic        soft_rst;
    logic        irq;

    int passed = 0;
    int total  = 0;

    sensemi_axi_regs_if #(.ADDR_WIDTH(13)) regs_if ();

    sensemi_axi_regs_bank #(
        .AXI_ADDR_WIDTH (13),
        .AXI_DATA_WIDTH (32),
        .BLOCK_ID       (EXP_ID),
        .VERSION        (EXP_VER),
        .NUM_IRQ        (8),
        .STATUS_W       (16),
        .CNT_W          (4)
    ) dut (
        .s_axi_aclk    (clk),
        .s_axi_aresetn (rst_n),
        .regs          (regs_if.slave),
        .ctrl_enable_o (ctrl_enable),
        .ctrl_mode_o   (ctrl_mode),
        .soft_rst_o    (soft_rst),
        .status_i      (status),
        .irq_event_i   (irq_ev),
        .cnt_event_i   (cnt_ev),
        .irq_o         (irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural model state
    logic [31:0] m_scratch;
    logic        m_en;
    logic [3:0]  m_mode;
    logic [7:0]  m_irq_st;
    logic [7:0]  m_mask;
    int          m_cnt;
    logic [31:0] m_rdata;
    logic        m_soft;
    logic        m_irq_o;

    function automatic logic [31:0] model_read(input logic [10:0] ofs, input logic [15:0] st);
        case (ofs)
            11'd0:   return EXP_ID;
            11'd1:   return EXP_VER;
            11'd2:   return m_scratch;
            11'd3:   return {24'h0, m_mode, 3'b000, m_en};
            11'd4:   return {16'h0, st};
            11'd5:   return {24'h0, m_irq_st};
            11'd6:   return {24'h0, m_mask};
            11'd7:   return m_cnt;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_clear();
        m_scratch = '0; m_en = 1'b0; m_mode = '0; m_irq_st = '0; m_mask = '0;
        m_cnt = 0; m_rdata = '0; m_soft = 1'b0; m_irq_o = 1'b0;
    endtask

    task automatic set_idle();
        regs_if.wren = 1'b0; regs_if.wr_offset = '0; regs_if.wdata = '0;
        regs_if.rden = 1'b0; regs_if.rd_offset = '0;
        irq_ev = '0; cnt_ev = 1'b0; status = '0;
    endtask

    // One clock cycle of stimulus; leaves time at posedge+1 with model updated
    task automatic cycle(input logic we, input logic [10:0] wo, input logic [31:0] wd,
                         input logic re, input logic [10:0] ro, input logic [7:0] ev,
                         input logic ce, input logic [15:0] st);
        logic [31:0] rv;
        logic        clr;
        regs_if.wren = we; regs_if.wr_offset = wo; regs_if.wdata = wd;
        regs_if.rden = re; regs_if.rd_offset = ro;
        irq_ev = ev; cnt_ev = ce; status = st;
        rv = model_read(ro, st);
        @(posedge clk);
        #1;
        m_irq_o = |(m_irq_st & m_mask);
        if (re) m_rdata = rv;
        m_soft = we && (wo == 11'd3) && wd[1];
`ifdef SENSEMI_REGS_CNT_CLR_ON_READ_EN
        clr = re && (ro == 11'd7);
`else
        clr = we && (wo == 11'd3) && wd[2];
`endif
        if (clr) m_cnt = ce ? 1 : 0;
        else if (ce && m_cnt < 15) m_cnt = m_cnt + 1;
        if (we && wo == 11'd5) m_irq_st = m_irq_st & ~wd[7:0];
        m_irq_st = m_irq_st | ev;
        if (we && wo == 11'd2) m_scratch = wd;
        if (we && wo == 11'd3) begin
            m_en = wd[0];
            m_mode = wd[7:4];
        end
        if (we && wo == 11'd6) m_mask = wd[7:0];
        set_idle();
    endtask

    task automatic wr(input logic [10:0] o, input logic [31:0] d);
        cycle(1'b1, o, d, 1'b0, 11'd0, 8'h0, 1'b0, 16'h0);
    endtask

    task automatic rd(input logic [10:0] o);
        cycle(1'b0, 11'd0, 32'h0, 1'b1, o, 8'h0, 1'b0, 16'h0);
    endtask

    task automatic do_reset();
        set_idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        model_clear();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (regs_if.rdata !== 32'h0) begin
            $display("FAIL reset_rdata: got %h expected %h", regs_if.rdata, 32'h0);
        end else passed++;
        total++; if ({ctrl_enable, ctrl_mode, soft_rst, irq} !== 7'h0) begin
            $display("FAIL reset_outputs: got %h expected %h",
                     {ctrl_enable, ctrl_mode, soft_rst, irq}, 7'h0);
        end else passed++;
        rd(11'd0);
        total++; if (regs_if.rdata !== EXP_ID) begin
            $display("FAIL read_id: got %h expected %h", regs_if.rdata, EXP_ID);
        end else passed++;
        rd(11'd1);
        total++; if (regs_if.rdata !== EXP_VER) begin
            $display("FAIL read_version: got %h expected %h", regs_if.rdata, EXP_VER);
        end else passed++;
    endtask

    task automatic test_scratch();
        wr(11'd2, 32'hA5A5_0F0F);
        rd(11'd2);
        total++; if (regs_if.rdata !== 32'hA5A5_0F0F) begin
            $display("FAIL scratch_rw: got %h expected %h", regs_if.rdata, 32'hA5A5_0F0F);
        end else passed++;
        cycle(1'b1, 11'd2, 32'h1234_5678, 1'b1, 11'd2, 8'h0, 1'b0, 16'h0);
        total++; if (regs_if.rdata !== 32'hA5A5_0F0F) begin
            $display("FAIL scratch_rw_same_cycle: got %h expected %h",
                     regs_if.rdata, 32'hA5A5_0F0F);
        end else passed++;
        rd(11'd2);
        total++; if (regs_if.rdata !== 32'h1234_5678) begin
            $display("FAIL scratch_after_collide: got %h expected %h",
                     regs_if.rdata, 32'h1234_5678);
        end else passed++;
    endtask

    task automatic test_ctrl();
        wr(11'd3, 32'h0000_0053);
        total++; if ({ctrl_enable, ctrl_mode, soft_rst} !== 6'b1_0101_1) begin
            $display("FAIL ctrl_outputs: got %b expected %b",
                     {ctrl_enable, ctrl_mode, soft_rst}, 6'b1_0101_1);
        end else passed++;
        rd(11'd3);
        total++; if (soft_rst !== 1'b0) begin
            $display("FAIL soft_rst_one_cycle: got %b expected %b", soft_rst, 1'b0);
        end else passed++;
        total++; if (regs_if.rdata !== 32'h0000_0051) begin
            $display("FAIL ctrl_readback: got %h expected %h", regs_if.rdata, 32'h51);
        end else passed++;
        rd(11'd4);
        total++; if (regs_if.rdata !== 32'h0) begin
            $display("FAIL status_zero: got %h expected %h", regs_if.rdata, 32'h0);
        end else passed++;
        cycle(1'b0, 11'd0, 32'h0, 1'b1, 11'd4, 8'h0, 1'b0, 16'hBEEF);
        total++; if (regs_if.rdata !== 32'h0000_BEEF) begin
            $display("FAIL status_read: got %h expected %h", regs_if.rdata, 32'hBEEF);
        end else passed++;
    endtask

    task automatic test_irq();
        wr(11'd6, 32'h0000_0008);
        cycle(1'b0, 11'd0, 32'h0, 1'b0, 11'd0, 8'h09, 1'b0, 16'h0);
        total++; if (irq !== 1'b0) begin
            $display("FAIL irq_latency: got %b expected %b", irq, 1'b0);
        end else passed++;
        rd(11'd5);
        total++; if (regs_if.rdata !== 32'h09 || irq !== 1'b1) begin
            $display("FAIL irq_set: got %h/%b expected %h/%b", regs_if.rdata, irq, 32'h09, 1'b1);
        end else passed++;
        // W1C on bits 0 and 3 while bit 3 fires again: bit 3 survives
        cycle(1'b1, 11'd5, 32'h09, 1'b0, 11'd0, 8'h08, 1'b0, 16'h0);
        rd(11'd5);
        total++; if (regs_if.rdata !== 32'h08) begin
            $display("FAIL irq_set_wins: got %h expected %h", regs_if.rdata, 32'h08);
        end else passed++;
        wr(11'd5, 32'h08);
        rd(11'd5);
        total++; if (regs_if.rdata !== 32'h0 || irq !== 1'b0) begin
            $display("FAIL irq_w1c: got %h/%b expected %h/%b", regs_if.rdata, irq, 32'h0, 1'b0);
        end else passed++;
    endtask

    task automatic test_counter();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            cycle(1'b0, 11'd0, 32'h0, 1'b0, 11'd0, 8'h0, 1'b1, 16'h0);
        end
`ifdef SENSEMI_REGS_CNT_CLR_ON_READ_EN
        cycle(1'b0, 11'd0, 32'h0, 1'b1, 11'd7, 8'h0, 1'b1, 16'h0);
        total++; if (regs_if.rdata !== 32'hF) begin
            $display("FAIL cnt_saturate: got %h expected %h", regs_if.rdata, 32'hF);
        end else passed++;
        rd(11'd7);
        total++; if (regs_if.rdata !== 32'h1) begin
            $display("FAIL cnt_clr_on_read: got %h expected %h", regs_if.rdata, 32'h1);
        end else passed++;
`else
        rd(11'd7);
        total++; if (regs_if.rdata !== 32'hF) begin
            $display("FAIL cnt_saturate: got %h expected %h", regs_if.rdata, 32'hF);
        end else passed++;
        rd(11'd7);
        total++; if (regs_if.rdata !== 32'hF) begin
            $display("FAIL cnt_read_no_side_effect: got %h expected %h", regs_if.rdata, 32'hF);
        end else passed++;
        cycle(1'b1, 11'd3, 32'h04, 1'b0, 11'd0, 8'h0, 1'b1, 16'h0);
        rd(11'd7);
        total++; if (regs_if.rdata !== 32'h1) begin
            $display("FAIL cnt_clr_with_event: got %h expected %h", regs_if.rdata, 32'h1);
        end else passed++;
        rd(11'd3);
        total++; if (regs_if.rdata !== 32'h0) begin
            $display("FAIL ctrl_cnt_clr_reads0: got %h expected %h", regs_if.rdata, 32'h0);
        end else passed++;
`endif
    endtask

    task automatic test_unmapped();
        rd(11'd0);
        wr(11'h3FF, 32'hFFFF_FFFF);
        rd(11'h3FF);
        total++; if (regs_if.rdata !== 32'h0) begin
            $display("FAIL unmapped_3ff: got %h expected %h", regs_if.rdata, 32'h0);
        end else passed++;
        rd(11'd0);
        rd(11'd8);
        total++; if (regs_if.rdata !== 32'h0) begin
            $display("FAIL unmapped_8: got %h expected %h", regs_if.rdata, 32'h0);
        end else passed++;
    endtask

    task automatic test_random();
        logic [10:0] ofs_tab [11];
        logic [10:0] wo, ro;
        logic        we, re, ce;
        logic [7:0]  ev;
        logic [31:0] wd;
        for (int i = 0; i < 10; i++) ofs_tab[i] = 11'(i);
        ofs_tab[10] = 11'h3FF;
        for (int n = 0; n < 400; n++) begin
            we = ($urandom_range(0, 2) == 0);
            re = ($urandom_range(0, 1) == 0);
            wo = ofs_tab[$urandom_range(0, 10)];
            ro = ofs_tab[$urandom_range(0, 10)];
            wd = $urandom;
            ev = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h0;
            ce = ($urandom_range(0, 2) != 0);
            cycle(we, wo, wd, re, ro, ev, ce, 16'($urandom));
            total++; if (regs_if.rdata !== m_rdata) begin
                $display("FAIL rand_rdata[%0d]: got %h expected %h", n, regs_if.rdata, m_rdata);
            end else passed++;
            total++; if ({ctrl_enable, ctrl_mode, soft_rst, irq} !==
                         {m_en, m_mode, m_soft, m_irq_o}) begin
                $display("FAIL rand_outputs[%0d]: got %b expected %b", n,
                         {ctrl_enable, ctrl_mode, soft_rst, irq}, {m_en, m_mode, m_soft, m_irq_o});
            end else passed++;
        end
    endtask

    task automatic test_reset_mid();
        wr(11'd6, 32'hFF);
        cycle(1'b1, 11'd3, 32'h03, 1'b0, 11'd0, 8'h01, 1'b0, 16'h0);
        rd(11'd2);
        total++; if (soft_rst !== 1'b0 || ctrl_enable !== 1'b1 || irq !== 1'b1) begin
            $display("FAIL pre_reset_state: got %b%b%b expected 011", soft_rst, ctrl_enable, irq);
        end else passed++;
        wr(11'd3, 32'h03);
        // soft_rst pulse pending and a read of ID in flight when reset hits
        regs_if.rden = 1'b1; regs_if.rd_offset = 11'd0;
        #2 rst_n = 1'b0;
        #1;
        total++; if ({ctrl_enable, ctrl_mode, soft_rst, irq} !== 7'h0) begin
            $display("FAIL midreset_outputs: got %h expected %h",
                     {ctrl_enable, ctrl_mode, soft_rst, irq}, 7'h0);
        end else passed++;
        @(posedge clk);
        #1;
        total++; if (regs_if.rdata !== 32'h0) begin
            $display("FAIL midreset_rdata: got %h expected %h", regs_if.rdata, 32'h0);
        end else passed++;
        set_idle();
        #3 rst_n = 1'b1;
        model_clear();
        @(posedge clk);
        #1;
        rd(11'd2);
        total++; if (regs_if.rdata !== 32'h0) begin
            $display("FAIL post_reset_scratch: got %h expected %h", regs_if.rdata, 32'h0);
        end else passed++;
    endtask

    initial begin
        rst_n = 1'b1;
        set_idle();
        model_clear();
        #1 rst_n = 1'b0;
        test_reset();
        test_scratch();
        test_ctrl();
        test_irq();
        test_counter();
        test_unmapped();
        do_reset();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
